// File: rtl/exception_ctrl_if.sv
// Coprocessor0 exception interface plus fetch-redirect handshake.
// The controller drives it through the master modport; CP0/fetch sit on the slave side.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

interface exception_ctrl_if;
    logic [`DATA_BUS] exception;
    logic [`ADDR_BUS] exc_pc;
    logic             flush;
    logic             redirect_valid;
    logic [`ADDR_BUS] redirect_pc;
    logic             redirect_ready;

    modport master (
        output exception,
        output exc_pc,
        output flush,
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  exception,
        input  exc_pc,
        input  flush,
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/exception_ctrl.sv
// MEM-stage exception/interrupt controller: picks one event per cycle, reports it to CP0,
// flushes the pipeline and redirects fetch to the handler vector or the ERET target.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef EXCEPT_NONE
`define EXCEPT_NONE      32'h0000_0000
`define EXCEPT_INTERRUPT 32'h0000_0001
`define EXCEPT_SYSCALL   32'h0000_0008
`define EXCEPT_ILLEGAL   32'h0000_000a
`define EXCEPT_OVERFLOW  32'h0000_000c
`define EXCEPT_TRAP      32'h0000_000d
`define EXCEPT_ERET      32'h0000_000e
`endif

module exception_ctrl #(
    parameter logic [`ADDR_BUS] EXC_VECTOR = 32'h0000_0380,
    parameter logic [4:0]       EPC_ADDR   = 5'd14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic             mem_stall,
    input  logic [`ADDR_BUS] mem_pc,
    input  logic             exc_syscall,
    input  logic             exc_illegal,
    input  logic             exc_trap,
    input  logic             exc_overflow,
    input  logic             exc_eret,
    input  logic [31:0]      cp0_status,
    input  logic [31:0]      cp0_cause,
    input  logic [`ADDR_BUS] cp0_epc,
    input  logic             timer_interrupt,
    input  logic             cp0_we,
    input  logic [4:0]       cp0_waddr,
    input  logic [`DATA_BUS] cp0_wdata,
    output logic             in_handler,
    exception_ctrl_if.master cp0_bus
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [`DATA_BUS] exception_q;
    logic [`DATA_BUS] exception_next;
    logic [`ADDR_BUS] exc_pc_q;
    logic [`ADDR_BUS] exc_pc_next;
    logic             redirect_valid_q;
    logic             redirect_valid_next;
    logic [`ADDR_BUS] redirect_pc_q;
    logic [`ADDR_BUS] redirect_pc_next;
    logic             in_handler_q;
    logic             in_handler_next;
    logic             flush_c;

    logic             irq_pending;
    logic             int_req;
    logic             accept;
    logic             has_event;
    logic             is_eret;
    logic [`DATA_BUS] event_code;
    logic [`ADDR_BUS] eret_target;
    logic             epc_forward;

    logic             unused_ok;
    assign unused_ok = &{1'b0, cp0_status[31:16], cp0_status[7:2],
                         cp0_cause[31:16], cp0_cause[7:0]};

    // Interrupts are masked by our own nesting flag as well as EXL, since EXL may only pulse.
    assign irq_pending = (|(cp0_cause[15:8] & cp0_status[15:8]))
                       | (timer_interrupt & cp0_status[15]);
    assign int_req     = cp0_status[0] & ~cp0_status[1] & ~in_handler_q & irq_pending;
    assign accept      = (state == IDLE) & mem_valid & ~mem_stall;

    // A CP0 write to EPC in the same cycle as ERET has not landed in cp0_epc yet.
    assign epc_forward = cp0_we & (cp0_waddr == EPC_ADDR);
    assign eret_target = epc_forward ? cp0_wdata : cp0_epc;

    always_comb begin
        event_code = `EXCEPT_NONE;
        has_event  = 1'b0;
        is_eret    = 1'b0;
        if (int_req) begin
            event_code = `EXCEPT_INTERRUPT;
            has_event  = 1'b1;
        end else if (exc_illegal) begin
            event_code = `EXCEPT_ILLEGAL;
            has_event  = 1'b1;
        end else if (exc_overflow) begin
            event_code = `EXCEPT_OVERFLOW;
            has_event  = 1'b1;
        end else if (exc_trap) begin
            event_code = `EXCEPT_TRAP;
            has_event  = 1'b1;
        end else if (exc_syscall) begin
            event_code = `EXCEPT_SYSCALL;
            has_event  = 1'b1;
        end else if (exc_eret) begin
            event_code = `EXCEPT_ERET;
            has_event  = 1'b1;
            is_eret    = 1'b1;
        end
    end

    always_comb begin
        state_next          = state;
        exception_next      = `EXCEPT_NONE;
        exc_pc_next         = exc_pc_q;
        redirect_valid_next = redirect_valid_q;
        redirect_pc_next    = redirect_pc_q;
        in_handler_next     = in_handler_q;
        flush_c             = 1'b0;
        case (state)
            IDLE: begin
                if (accept && has_event) begin
                    flush_c             = 1'b1;
                    exception_next      = event_code;
                    exc_pc_next         = mem_pc;
                    redirect_valid_next = 1'b1;
                    redirect_pc_next    = is_eret ? eret_target : EXC_VECTOR;
                    in_handler_next     = ~is_eret;
                    state_next          = REDIRECT;
                end
            end
            REDIRECT: begin
                flush_c = 1'b1;
                if (redirect_valid_q && cp0_bus.redirect_ready) begin
                    redirect_valid_next = 1'b0;
                    state_next          = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            exception_q      <= `EXCEPT_NONE;
            exc_pc_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            in_handler_q     <= 1'b0;
        end else begin
            state            <= state_next;
            exception_q      <= exception_next;
            exc_pc_q         <= exc_pc_next;
            redirect_valid_q <= redirect_valid_next;
            redirect_pc_q    <= redirect_pc_next;
            in_handler_q     <= in_handler_next;
        end
    end

    // Flush is combinational so the MEM instruction never commits; reset overrides it.
    assign cp0_bus.flush          = rst_n & flush_c;
    assign cp0_bus.exception      = exception_q;
    assign cp0_bus.exc_pc         = exc_pc_q;
    assign cp0_bus.redirect_valid = redirect_valid_q;
    assign cp0_bus.redirect_pc    = redirect_pc_q;
    assign in_handler             = in_handler_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: stimulus pushes expected events into a scoreboard,
// a negedge monitor pops and compares whenever the DUT reports an exception.
module tb_exception_ctrl;

    localparam logic [31:0] C_NONE = 32'h0;
    localparam logic [31:0] C_INT  = 32'h1;
    localparam logic [31:0] C_SYS  = 32'h8;
    localparam logic [31:0] C_ILL  = 32'ha;
    localparam logic [31:0] C_OVF  = 32'hc;
    localparam logic [31:0] C_TRAP = 32'hd;
    localparam logic [31:0] C_ERET = 32'he;
    localparam logic [31:0] VEC    = 32'h380;

    localparam logic [4:0] F_ILL  = 5'b10000;
    localparam logic [4:0] F_OVF  = 5'b01000;
    localparam logic [4:0] F_TRAP = 5'b00100;
    localparam logic [4:0] F_SYS  = 5'b00010;
    localparam logic [4:0] F_ERET = 5'b00001;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic [31:0] target;
        logic        handler;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, mem_stall;
    logic [31:0] mem_pc;
    logic        exc_syscall, exc_illegal, exc_trap, exc_overflow, exc_eret;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        timer_interrupt;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        in_handler;

    exception_ctrl_if ex_if ();

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    exception_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_valid       (mem_valid),
        .mem_stall       (mem_stall),
        .mem_pc          (mem_pc),
        .exc_syscall     (exc_syscall),
        .exc_illegal     (exc_illegal),
        .exc_trap        (exc_trap),
        .exc_overflow    (exc_overflow),
        .exc_eret        (exc_eret),
        .cp0_status      (cp0_status),
        .cp0_cause       (cp0_cause),
        .cp0_epc         (cp0_epc),
        .timer_interrupt (timer_interrupt),
        .cp0_we          (cp0_we),
        .cp0_waddr       (cp0_waddr),
        .cp0_wdata       (cp0_wdata),
        .in_handler      (in_handler),
        .cp0_bus         (ex_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one MEM-stage instruction for a cycle, starting at a negedge.
    task automatic apply_stimulus(input string name, input logic [31:0] pc, input logic [4:0] flags,
                                  input bit taken, input logic [31:0] code,
                                  input logic [31:0] target, input bit handler);
        exp_t e;
        mem_valid = 1'b1;
        mem_stall = 1'b0;
        mem_pc    = pc;
        {exc_illegal, exc_overflow, exc_trap, exc_syscall, exc_eret} = flags;
        if (taken) begin
            e.code = code; e.pc = pc; e.target = target; e.handler = handler;
            sb.push_back(e);
        end
        #1 check_output({name, " flush"}, 32'(ex_if.flush), 32'(taken));
        @(negedge clk);
        mem_valid = 1'b0;
        {exc_illegal, exc_overflow, exc_trap, exc_syscall, exc_eret} = 5'b0;
        cp0_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        ex_if.redirect_ready = 1'b1;
        while (ex_if.redirect_valid !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: redirect_valid still %b after %0d cycles, expected 0",
                     ex_if.redirect_valid, n);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ex_if.exception !== C_NONE) begin
            if (sb.size() == 0) begin
                check_output("unexpected event", ex_if.exception, C_NONE);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("sb exception", ex_if.exception, e.code);
                check_output("sb exc_pc", ex_if.exc_pc, e.pc);
                check_output("sb redirect_pc", ex_if.redirect_pc, e.target);
                check_output("sb redirect_valid", 32'(ex_if.redirect_valid), 32'h1);
                check_output("sb in_handler", 32'(in_handler), 32'(e.handler));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b1; mem_stall = 1'b0; mem_pc = 32'h0;
        exc_syscall = 1'b1; exc_illegal = 1'b0; exc_trap = 1'b0; exc_overflow = 1'b0; exc_eret = 1'b0;
        cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0; timer_interrupt = 1'b0;
        cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'h0;
        ex_if.redirect_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset exception", ex_if.exception, C_NONE);
        check_output("reset flush", 32'(ex_if.flush), 32'h0);
        check_output("reset redirect_valid", 32'(ex_if.redirect_valid), 32'h0);
        check_output("reset redirect_pc", ex_if.redirect_pc, 32'h0);
        check_output("reset exc_pc", ex_if.exc_pc, 32'h0);
        check_output("reset in_handler", 32'(in_handler), 32'h0);
        exc_syscall = 1'b0;
        mem_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus("syscall", 32'h40, F_SYS, 1'b1, C_SYS, VEC, 1'b1);
        @(negedge clk);
        check_output("syscall after exception", ex_if.exception, C_NONE);
        check_output("syscall after redirect_valid", 32'(ex_if.redirect_valid), 32'h0);
        check_output("syscall after flush", 32'(ex_if.flush), 32'h0);
        wait_idle();

        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h200; cp0_epc = 32'h100;
        apply_stimulus("eret fwd", 32'h60, F_ERET, 1'b1, C_ERET, 32'h200, 1'b0);
        wait_idle();

        cp0_status = 32'h0000_8001; timer_interrupt = 1'b1;
        apply_stimulus("int vs ovf", 32'h100, F_OVF, 1'b1, C_INT, VEC, 1'b1);
        wait_idle();
        apply_stimulus("int blocked", 32'h104, 5'b0, 1'b0, C_NONE, 32'h0, 1'b0);
        apply_stimulus("ovf in handler", 32'h120, F_OVF, 1'b1, C_OVF, VEC, 1'b1);
        wait_idle();
        timer_interrupt = 1'b0;

        ex_if.redirect_ready = 1'b0;
        apply_stimulus("illegal prio", 32'h80, F_ILL | F_TRAP | F_SYS, 1'b1, C_ILL, VEC, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_output("bp redirect_valid", 32'(ex_if.redirect_valid), 32'h1);
            check_output("bp redirect_pc", ex_if.redirect_pc, VEC);
            check_output("bp flush", 32'(ex_if.flush), 32'h1);
            if (i == 0) begin
                mem_valid = 1'b1; mem_pc = 32'h84; exc_trap = 1'b1;
            end else if (i == 1) begin
                mem_valid = 1'b0; exc_trap = 1'b0;
            end else begin
                ex_if.redirect_ready = 1'b1;
            end
            @(negedge clk);
        end
        check_output("bp idle redirect_valid", 32'(ex_if.redirect_valid), 32'h0);
        check_output("bp idle flush", 32'(ex_if.flush), 32'h0);

        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'hdead; cp0_epc = 32'h300;
        apply_stimulus("eret epc", 32'h90, F_ERET, 1'b1, C_ERET, 32'h300, 1'b0);
        wait_idle();
        cp0_epc = 32'h340;
        apply_stimulus("eret no handler", 32'ha0, F_ERET, 1'b1, C_ERET, 32'h340, 1'b0);
        wait_idle();
        apply_stimulus("trap prio", 32'ha4, F_TRAP | F_SYS | F_ERET, 1'b1, C_TRAP, VEC, 1'b1);
        wait_idle();
        apply_stimulus("eret clear", 32'ha8, F_ERET, 1'b1, C_ERET, 32'h340, 1'b0);
        wait_idle();

        cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
        apply_stimulus("ip interrupt", 32'hb0, F_ERET, 1'b1, C_INT, VEC, 1'b1);
        wait_idle();
        apply_stimulus("eret after int", 32'hb4, F_ERET, 1'b1, C_ERET, 32'h340, 1'b0);
        wait_idle();
        cp0_status = 32'h0000_0403;
        apply_stimulus("exl blocks int", 32'hc0, F_SYS, 1'b1, C_SYS, VEC, 1'b1);
        wait_idle();
        cp0_status = 32'h0; cp0_cause = 32'h0;

        mem_valid = 1'b1; mem_stall = 1'b1; mem_pc = 32'hd0; exc_trap = 1'b1;
        #1 check_output("stall flush", 32'(ex_if.flush), 32'h0);
        @(negedge clk);
        check_output("stall exception", ex_if.exception, C_NONE);
        mem_stall = 1'b0; mem_valid = 1'b0;
        #1 check_output("invalid flush", 32'(ex_if.flush), 32'h0);
        @(negedge clk);
        check_output("invalid exception", ex_if.exception, C_NONE);
        check_output("invalid redirect_valid", 32'(ex_if.redirect_valid), 32'h0);
        exc_trap = 1'b0;

        repeat (2) @(negedge clk);
        check_output("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
